// File: rtl/sli_rst_sequencer_if.sv
// Handshake bundle for sli_rst_sequencer: software request and delay config in,
// per-domain active-low resets and status out.
interface sli_rst_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic                    sw_rst_req;
  logic [NUM_CH*CNT_W-1:0] dly_cfg;
  logic [NUM_CH-1:0]       ch_rst_n;
  logic                    busy;
  logic                    seq_done;

  modport master (output sw_rst_req, dly_cfg, input ch_rst_n, busy, seq_done);
  modport slave  (input sw_rst_req, dly_cfg, output ch_rst_n, busy, seq_done);
endinterface

// File: rtl/sli_rst_sequencer.sv
// Reset sequencer: asserts NUM_CH active-low domain resets together, releases them in ascending
// order with programmable spacing. Define SLI_RST_REQ_FILTER_EN to debounce sw_rst_req (2 cycles).
module sli_rst_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 8
) (
  input logic                clk,
  input logic                reset,
  sli_rst_sequencer_if.slave bus
);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int CW     = (CNT_W > HOLD_W) ? CNT_W : HOLD_W;
  localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CH - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {SYNC, HOLD, SEQ, DONE} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [NUM_CH-1:0]      ch, ch_nxt;
  logic                   seq_done, seq_done_nxt;
  logic                   busy, busy_nxt;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_out;
  logic                   req_acc;

  function automatic logic [CW-1:0] dly_field(input logic [NUM_CH*CNT_W-1:0] cfg,
                                              input logic [IW-1:0] i);
    return CW'(cfg[int'(i)*CNT_W +: CNT_W]);
  endfunction

  // Reset release is synchronised; assertion stays asynchronous
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_chain <= '0;
    else       sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
  end
  assign sync_out = sync_chain[SYNC_STAGES-1];

`ifdef SLI_RST_REQ_FILTER_EN
  logic req_d1, req_filt, req_filt_d1;
  assign req_filt = bus.sw_rst_req & req_d1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_d1      <= 1'b0;
      req_filt_d1 <= 1'b0;
    end else begin
      req_d1      <= bus.sw_rst_req;
      req_filt_d1 <= req_filt;
    end
  end
  // One acceptance per rising edge of the 2-cycle-qualified request
  assign req_acc = req_filt & ~req_filt_d1;
`else
  assign req_acc = bus.sw_rst_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SYNC;
      cnt      <= '0;
      idx      <= '0;
      ch       <= '0;
      seq_done <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      ch       <= ch_nxt;
      seq_done <= seq_done_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    ch_nxt       = ch;
    seq_done_nxt = seq_done;
    busy_nxt     = busy;
    unique case (state)
      SYNC: begin
        if (sync_out) begin
          state_nxt = SEQ;
          idx_nxt   = '0;
          cnt_nxt   = dly_field(bus.dly_cfg, '0);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = SEQ;
          idx_nxt   = '0;
          cnt_nxt   = dly_field(bus.dly_cfg, '0);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SEQ: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          ch_nxt[idx] = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt    = DONE;
            seq_done_nxt = 1'b1;
            busy_nxt     = 1'b0;
          end else begin
            idx_nxt = idx + 1'b1;
            cnt_nxt = dly_field(bus.dly_cfg, idx + 1'b1);
          end
        end
      end
      DONE: begin
        seq_done_nxt = 1'b1;
        busy_nxt     = 1'b0;
      end
      default: state_nxt = SYNC;
    endcase
    // A request overrides whatever the current state would do, except while resynchronising
    if (req_acc && (state != SYNC)) begin
      state_nxt    = HOLD;
      cnt_nxt      = HOLD_LOAD;
      idx_nxt      = '0;
      ch_nxt       = '0;
      seq_done_nxt = 1'b0;
      busy_nxt     = 1'b1;
    end
  end

  assign bus.ch_rst_n = ch;
  assign bus.seq_done = seq_done;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_sli_rst_sequencer.sv
// Bench for sli_rst_sequencer: schedule-based reference model checked every cycle,
// directed scenarios with literal release times, then randomized requests/config/resets.
module tb_sli_rst_sequencer;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYC    = 8;
  localparam longint INF     = 64'h0000_0100_0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sli_rst_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  sli_rst_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cur = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute edge numbers at which each channel is released
  longint edge_n = 0;
  longint m_seq_start = INF;
  longint m_rel [NUM_CH];
  bit m_in_reset = 1'b1;
  bit m_in_sync = 1'b1;
  bit m_prev_req = 1'b0;
  bit m_prev_filt = 1'b0;
  logic [NUM_CH-1:0] exp_ch;

  function automatic longint fld(input int i);
    logic [NUM_CH*CNT_W-1:0] cfg;
    cfg = bus.dly_cfg;
    return longint'(cfg[i*CNT_W +: CNT_W]);
  endfunction

  always @(posedge clk or posedge reset) begin
    bit acc;
    bit filt;
    if (reset) begin
      m_in_reset = 1'b1;
      m_in_sync = 1'b1;
      m_seq_start = INF;
      for (int i = 0; i < NUM_CH; i++) m_rel[i] = INF;
      m_prev_req = 1'b0;
      m_prev_filt = 1'b0;
    end else begin
      edge_n++;
      if (m_in_reset) begin
        m_in_reset = 1'b0;
        m_seq_start = edge_n + SYNC_STAGES;
      end
`ifdef SLI_RST_REQ_FILTER_EN
      filt = bus.sw_rst_req && m_prev_req;
      acc = filt && !m_prev_filt;
      m_prev_req = bus.sw_rst_req;
      m_prev_filt = filt;
`else
      filt = 1'b0;
      acc = bus.sw_rst_req;
`endif
      if (m_in_sync) acc = 1'b0;
      if (acc) begin
        for (int i = 0; i < NUM_CH; i++) m_rel[i] = INF;
        m_seq_start = edge_n + HOLD_CYC;
      end else begin
        for (int i = 0; i < NUM_CH - 1; i++)
          if (m_rel[i] == edge_n) m_rel[i+1] = edge_n + fld(i+1) + 1;
        if (edge_n == m_seq_start) begin
          m_rel[0] = edge_n + fld(0) + 1;
          m_in_sync = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NUM_CH; i++) exp_ch[i] = !m_in_reset && (m_rel[i] <= edge_n);
      chk("ch_rst_n", bus.ch_rst_n, exp_ch);
      chk("seq_done", bus.seq_done, &exp_ch);
      chk("busy", bus.busy, ~&exp_ch);
    end
  end

  task automatic goto(input int c);
    repeat (c - cur) @(negedge clk);
    cur = c;
  endtask

  task automatic pulse_req();
    bus.sw_rst_req = 1'b1;
    goto(cur + 1);
`ifdef SLI_RST_REQ_FILTER_EN
    goto(cur + 1);
`endif
    bus.sw_rst_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ch", bus.ch_rst_n, 4'h0);
    chk("async_rst_busy", bus.busy, 1'b1);
    chk("async_rst_done", bus.seq_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cur = -1;
  endtask

  // Release times for dly_cfg = {3,0,2,5}, counted from the first edge after reset falls
  task automatic seq_literals();
    goto(7);  chk("s1_c7", bus.ch_rst_n, 4'h0);
    goto(8);  chk("s1_c8", bus.ch_rst_n, 4'h1);
    goto(10); chk("s1_c10", bus.ch_rst_n, 4'h1);
    goto(11); chk("s1_c11", bus.ch_rst_n, 4'h3);
    goto(12); chk("s1_c12", bus.ch_rst_n, 4'h7);
    goto(15); chk("s1_c15", bus.ch_rst_n, 4'h7);
    chk("s1_c15_done", bus.seq_done, 1'b0);
    goto(16); chk("s1_c16", bus.ch_rst_n, 4'hF);
    chk("s1_c16_done", bus.seq_done, 1'b1);
    chk("s1_c16_busy", bus.busy, 1'b0);
    chk("model_span", 32'(m_rel[3] - m_rel[0]), 32'd8);
  endtask

  initial begin
    int a;
    int b;
    int c;
    int r;
    int req_hold;
    reset = 1'b1;
    bus.sw_rst_req = 1'b0;
    bus.dly_cfg = {8'd3, 8'd0, 8'd2, 8'd5};
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_ch", bus.ch_rst_n, 4'h0);
    chk("reset_busy", bus.busy, 1'b1);
    chk("reset_done", bus.seq_done, 1'b0);

    // Power-up sequence
    reset = 1'b0;
    cur = -1;
    seq_literals();

    // One-cycle software request from DONE
    goto(cur + 2);
    bus.sw_rst_req = 1'b1;
    goto(cur + 1);
    bus.sw_rst_req = 1'b0;
`ifdef SLI_RST_REQ_FILTER_EN
    chk("pulse_ignored_ch", bus.ch_rst_n, 4'hF);
    chk("pulse_ignored_done", bus.seq_done, 1'b1);
    goto(cur + 3);
    pulse_req();
`endif
    a = cur;
    chk("req_ch", bus.ch_rst_n, 4'h0);
    chk("req_done", bus.seq_done, 1'b0);
    chk("req_busy", bus.busy, 1'b1);
    goto(a + 13); chk("s2_a13", bus.ch_rst_n, 4'h0);
    goto(a + 14); chk("s2_a14", bus.ch_rst_n, 4'h1);
    goto(a + 17); chk("s2_a17", bus.ch_rst_n, 4'h3);
    goto(a + 18); chk("s2_a18", bus.ch_rst_n, 4'h7);
    goto(a + 21); chk("s2_a21", bus.ch_rst_n, 4'h7);
    goto(a + 22); chk("s2_a22", bus.ch_rst_n, 4'hF);

    // Abort mid-sequence after ch0 and ch1 released
    goto(cur + 2);
    pulse_req();
    b = cur;
    goto(b + 17); chk("s3_b17", bus.ch_rst_n, 4'h3);
    pulse_req();
    c = cur;
    chk("abort_ch", bus.ch_rst_n, 4'h0);
    chk("abort_busy", bus.busy, 1'b1);
    goto(c + 13); chk("s3_c13", bus.ch_rst_n, 4'h0);
    goto(c + 14); chk("s3_c14", bus.ch_rst_n, 4'h1);
    goto(c + 19);

    // Asynchronous reset mid-sequence, then resync
    do_reset();
    seq_literals();

    // Maximum delays: 256-cycle spacing, no wrap
    bus.dly_cfg = {NUM_CH*CNT_W{1'b1}};
    do_reset();
    goto(257);  chk("s5_c257", bus.ch_rst_n, 4'h0);
    goto(258);  chk("s5_c258", bus.ch_rst_n, 4'h1);
    goto(514);  chk("s5_c514", bus.ch_rst_n, 4'h3);
    goto(770);  chk("s5_c770", bus.ch_rst_n, 4'h7);
    goto(1025); chk("s5_c1025", bus.ch_rst_n, 4'h7);
    goto(1026); chk("s5_c1026", bus.ch_rst_n, 4'hF);

    // Delay field sampled only when loaded
    bus.dly_cfg = {8'd3, 8'd2, 8'd0, 8'd5};
    do_reset();
    goto(4);  bus.dly_cfg[15:8] = 8'd9;
    goto(8);  chk("s6_c8", bus.ch_rst_n, 4'h1);
    goto(12); bus.dly_cfg[15:8] = 8'd0;
    goto(17); chk("s6_c17", bus.ch_rst_n, 4'h1);
    goto(18); chk("s6_c18", bus.ch_rst_n, 4'h3);
    goto(21); chk("s6_c21", bus.ch_rst_n, 4'h7);
    goto(25); chk("s6_c25", bus.ch_rst_n, 4'hF);

    // Randomized requests, config changes and asynchronous resets
    req_hold = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 999));
      if (req_hold > 0) begin
        bus.sw_rst_req = 1'b1;
        req_hold--;
      end else begin
        bus.sw_rst_req = (r < 15);
      end
      if (r >= 15 && r < 25) req_hold = int'($urandom_range(1, 12));
      if ($urandom_range(0, 49) == 0)
        for (int i = 0; i < NUM_CH; i++) bus.dly_cfg[i*CNT_W +: CNT_W] = 8'($urandom_range(0, 6));
      if (r >= 997) do_reset();
    end
    bus.sw_rst_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sli_rst_sequencer.md
Name: sli_rst_sequencer

Overview:
Parametrised reset controller for SLI test environments and DUT wrappers. It takes one clock and one global asynchronous active-high reset. It generates NUM_CH active-low domain resets that assert together and release one after another, with a programmable per-channel delay. A software reset request re-runs the whole sequence without pulsing the global reset.

Parameters:
NUM_CH, 4, number of reset domains driven (1..16)
CNT_W, 8, width of each per-channel delay field
SYNC_STAGES, 2, synchroniser depth on global reset deassertion (>=2)
HOLD_CYC, 8, cycles all channels stay asserted after a software reset request (>=1)

Ports:
clk  input  1  single clock for all logic
reset  input  1  global reset, asynchronous, active-high
sw_rst_req  input  1  software reset request, sampled on clk
dly_cfg  input  NUM_CH*CNT_W  per-channel release delay; field i = bits [i*CNT_W +: CNT_W]
ch_rst_n  output  NUM_CH  per-domain reset, active-low
busy  output  1  high while any channel is held or sequencing
seq_done  output  1  high when all channels are released

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port reset.
- reset=1 takes effect immediately, with no clk edge needed:
  - ch_rst_n = 0 on all channels, busy = 1, seq_done = 0;
  - FSM = SYNC, synchroniser cleared, counter = 0, channel index = 0.
- Deassertion of reset is synchronised: a SYNC_STAGES-flop chain shifts in 1 after reset falls.
- FSM states: SYNC, HOLD, SEQ, DONE.
- SYNC: wait until the chain output is 1. Then go to SEQ with index 0 and counter loaded from dly_cfg[0].
- SEQ:
  - Each cycle, counter decrements while counter != 0.
  - In the cycle where counter == 0, ch_rst_n[index] is set to 1 at the next edge.
  - If index < NUM_CH-1: index increments and counter loads dly_cfg[index+1].
  - Otherwise the FSM goes to DONE.
  - Resulting spacing: ch_rst_n[i] rises exactly dly_cfg[i]+1 cycles after ch_rst_n[i-1] rises. Channel 0 is measured from the first SEQ cycle.
  - Delay 0 gives a minimum spacing of 1 cycle.
  - dly_cfg is sampled only when a field is loaded. Later changes do not affect the channel currently counting.
- DONE: busy = 0, seq_done = 1, all ch_rst_n = 1. The FSM stays here until a request is accepted.
- Accepted sw_rst_req, in any state except SYNC:
  - all ch_rst_n = 0 at the next edge, seq_done = 0, busy = 1;
  - counter = HOLD_CYC-1, FSM = HOLD.
  - A request in SEQ aborts the sequence.
  - A request in HOLD restarts the hold count.
  - A request in SYNC is ignored.
- HOLD: counter decrements each cycle. At counter == 0, go to SEQ with index 0 and load dly_cfg[0]. All channels stay asserted for exactly HOLD_CYC cycles.
- Release order is fixed: ascending index, never reordered. Once released, a channel never re-asserts except via reset or an accepted request.
- Outputs are registered only; there are no combinational paths from inputs to outputs.
- busy = ~seq_done at all times outside reset.

Optional Feature:
SLI_RST_REQ_FILTER_EN:
- Defined: sw_rst_req is accepted only after it has been high for 2 consecutive clk cycles. Acceptance happens on the second cycle. A 1-cycle pulse is ignored. A request held continuously is accepted once per rising edge of the filtered signal, not every cycle. The filter flop is cleared by reset.
- Undefined: any cycle with sw_rst_req = 1 is accepted, as described in Behaviour. Holding sw_rst_req high keeps HOLD restarting.

Test Plan:
1. NUM_CH=4, dly_cfg={3,0,2,5} (ch3..ch0), reset falls at cycle 0 -> SEQ entered at cycle 2; ch0 rises at cycle 8, ch1 at 11, ch2 at 12, ch3 at 16; seq_done=1 and busy=0 from cycle 16.
2. In DONE, 1-cycle sw_rst_req=1 -> all ch_rst_n=0 the next cycle, held 8 cycles, then the sequence re-runs with the test 1 spacing (6/3/1/4 cycles); filter enabled: the same pulse is ignored, so seq_done stays 1.
3. sw_rst_req during SEQ after ch0 and ch1 are released -> ch0 and ch1 drop to 0 the next cycle; a full HOLD of 8 cycles follows; the sequence restarts from ch0.
4. reset asserted mid-SEQ between clk edges -> ch_rst_n=0, busy=1, seq_done=0 immediately with no clk edge; after release, resync takes 2 cycles before SEQ.
5. All dly_cfg fields = 8'hFF -> each channel spaced 256 cycles apart; ch3 rises 1024 cycles after SEQ entry; no counter wrap.
6. dly_cfg[1] changed from 0 to 9 while ch0 is counting -> ch1 uses 9 (loaded after ch0 releases); a change during ch1's count has no effect on ch1.
